// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Owns the architectural HI/LO registers and exposes them continuously.
// A MULT/MULTU/DIV/DIVU takes 33 clocks. One bit is processed per cycle,
// and a final fix-up cycle applies the signs and writes HI/LO.
// MTHI/MTLO write HI/LO directly in a single edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] FC_MULT  = 6'b011000;
  localparam logic [5:0] FC_MULTU = 6'b011001;
  localparam logic [5:0] FC_DIV   = 6'b011010;
  localparam logic [5:0] FC_DIVU  = 6'b011011;
  localparam logic [5:0] FC_MTHI  = 6'b010001;
  localparam logic [5:0] FC_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [WIDTH-1:0]   aOrig_q, aOrig_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               opMul;
  logic               opDiv;
  logic               opSigned;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divDiff;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quoFixed;
  logic [WIDTH-1:0]   remFixed;

  // Decode the request. Signed ops work on magnitudes; the most negative value maps onto itself as an unsigned magnitude.
  assign opMul    = (func_code == FC_MULT) || (func_code == FC_MULTU);
  assign opDiv    = (func_code == FC_DIV)  || (func_code == FC_DIVU);
  assign opSigned = (func_code == FC_MULT) || (func_code == FC_DIV);
  assign magA     = (opSigned && a[WIDTH-1]) ? -a : a;
  assign magB     = (opSigned && b[WIDTH-1]) ? -b : b;

  // Shift-add step. The low half of acc holds the remaining multiplier bits, and the high half accumulates the product.
  assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);

  // Restoring-divide step. Shift the next dividend bit into the remainder, then subtract when the divisor fits.
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opB_q};
  assign divDiff  = divShift[WIDTH-1:0] - opB_q;
  assign divRem   = divFits ? divDiff : divShift[WIDTH-1:0];

  // Sign fix-up applied in the final cycle.
  assign prodFixed = negRes_q ? -acc_q : acc_q;
  assign quoFixed  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFixed  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // State and datapath register bank. Reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opB_q    <= '0;
      aOrig_q  <= '0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opB_q    <= opB_d;
      aOrig_q  <= aOrig_d;
      isDiv_q  <= isDiv_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state logic. Requests are accepted only in IDLE; iterate WIDTH times, then write HI/LO in FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opB_d    = opB_q;
    aOrig_d  = aOrig_q;
    isDiv_d  = isDiv_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (func_code == FC_MTHI) begin
            hi_d  = a;
            dbz_d = 1'b0;
          end else if (func_code == FC_MTLO) begin
            lo_d  = a;
            dbz_d = 1'b0;
          end else if (opMul || opDiv) begin
            state_d  = opDiv ? ST_DIV : ST_MUL;
            cnt_d    = '0;
            busy_d   = 1'b1;
            dbz_d    = opDiv && (b == '0);
            aOrig_d  = a;
            isDiv_d  = opDiv;
            negRes_d = opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem_d = (func_code == FC_DIV) && a[WIDTH-1];
            if (opDiv) begin
              acc_d = {{WIDTH{1'b0}}, magA};
              opB_d = magB;
            end else begin
              acc_d = {{WIDTH{1'b0}}, magB};
              opB_d = magA;
            end
          end
        end
      end

      ST_MUL: begin
        acc_d = {mulSum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_DIV: begin
        acc_d = {divRem, acc_q[WIDTH-2:0], divFits};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (!isDiv_q) begin
          hi_d = prodFixed[2*WIDTH-1:WIDTH];
          lo_d = prodFixed[WIDTH-1:0];
        end else if (dbz_q) begin
          hi_d = aOrig_q;
          lo_d = '1;
        end else begin
          hi_d = remFixed;
          lo_d = quoFixed;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
